// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the configurable UART transmitter
package uart_pkg;

    // Divisor for 115200 baud from a 50 MHz clock
    localparam int DEFAULT_DIV = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5,
        MAB    = 3'd6
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    // Only even and odd produce a parity bit; the reserved code behaves as none
    function automatic logic par_enabled(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter that ticks on the last clock of each period
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    // A zero period is treated as one clock so the counter can never run away
    assign w_last = (period == '0) ? '0 : (period - DIV_W'(1));
    assign tick   = !clear && (r_cnt == w_last);

    // Count 0..period-1, restarting on the terminal count or while held clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - run-time configurable UART transmitter; UART_TX_BREAK_EN adds brk/BREAK/MAB
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            r_state;
    tx_state_e            w_next_state;
    logic [DATA_BITS-1:0] r_data;
    logic [DIV_W-1:0]     r_div;
    parity_e              r_par;
    logic                 r_stop2;
    logic                 r_stop_second;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_tx;
    logic                 r_done;

    logic                 w_tick;
    logic                 w_clear;
    logic [DIV_W-1:0]     w_period;
    logic [IDX_W-1:0]     w_next_idx;
    logic                 w_next_stop_second;
    logic                 w_next_tx;
    logic                 w_frame_end;
    logic                 w_par_bit;
    logic                 w_leave_idle;

    // Counter sits at zero whenever no timed state is active, so every timed state starts fresh
    assign w_clear      = (r_state == IDLE) || (r_state == BREAK);
    assign w_period     = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign w_par_bit    = (^r_data) ^ (r_par == PAR_ODD);
    assign w_leave_idle = (r_state == IDLE) && (w_next_state != IDLE);

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .period (r_div),
        .tick   (w_tick)
    );

    // Next-state, bit index, stop-half tracking and the tx level for the next cycle
    always_comb begin
        w_next_state       = r_state;
        w_next_idx         = r_idx;
        w_next_stop_second = r_stop_second;
        w_frame_end        = 1'b0;
        w_next_tx          = 1'b1;

        case (r_state)
            IDLE: begin
                w_next_stop_second = 1'b0;
`ifdef UART_TX_BREAK_EN
                if (brk) begin
                    w_next_state = BREAK;
                end else if (valid) begin
                    w_next_state = START;
                end
`else
                if (valid) begin
                    w_next_state = START;
                end
`endif
            end
            START: begin
                if (w_tick) begin
                    w_next_state = DATA;
                    w_next_idx   = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_idx == LAST_IDX) begin
                        w_next_state = par_enabled(r_par) ? PARITY : STOP;
                    end else begin
                        w_next_idx = r_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_stop2 && !r_stop_second) begin
                        w_next_stop_second = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                        w_frame_end  = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (!brk) begin
                    w_next_state = MAB;
                end
            end
            MAB: begin
                if (w_tick) begin
                    w_next_state = IDLE;
                end
            end
`endif
            default: begin
                w_next_state = IDLE;
            end
        endcase

        case (w_next_state)
            START:   w_next_tx = 1'b0;
            DATA:    w_next_tx = r_data[w_next_idx];
            PARITY:  w_next_tx = w_par_bit;
            BREAK:   w_next_tx = 1'b0;
            default: w_next_tx = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Frame settings are captured on leaving IDLE; tx and done are registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data        <= '0;
            r_div         <= DIV_W'(1);
            r_par         <= PAR_NONE;
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
            r_idx         <= '0;
            r_tx          <= 1'b1;
            r_done        <= 1'b0;
        end else begin
            if (w_leave_idle) begin
                r_data  <= data;
                r_div   <= w_period;
                r_par   <= parity_e'(parity_mode);
                r_stop2 <= stop2;
            end
            r_stop_second <= w_next_stop_second;
            r_idx         <= w_next_idx;
            r_tx          <= w_next_tx;
            r_done        <= w_frame_end;
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state != IDLE);
    assign tx    = r_tx;
    assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg
module tb_uart_tx_cfg;

    localparam int DATA_BITS = 8;
    localparam int DIV_W     = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DIV_W-1:0]     baud_div;
    logic [1:0]           parity_mode;
    logic                 stop2;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
`ifdef UART_TX_BREAK_EN
    logic                 brk;
`endif
    logic                 ready;
    logic                 tx;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    uart_tx_cfg #(
        .DATA_BITS (DATA_BITS),
        .DIV_W     (DIV_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .data        (data),
        .valid       (valid),
`ifdef UART_TX_BREAK_EN
        .brk         (brk),
`endif
        .ready       (ready),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int eff_p(input logic [DIV_W-1:0] div);
        return (div == '0) ? 1 : int'(div);
    endfunction

    // Reference frame: start, data LSB first, optional parity, one or two stops
    task automatic push_frame(input logic [7:0] d, input int p, input logic [1:0] pm, input logic s2);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pm == 2'b01) bits.push_back(^d);
        if (pm == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int j = 0; j < p; j++) exp_q.push_back(bits[k]);
        end
    endtask

    // Present a word, let it be accepted, then scramble the inputs to prove they were latched
    task automatic drive_accept(input logic [7:0] d, input logic [DIV_W-1:0] div,
                                input logic [1:0] pm, input logic s2);
        @(negedge clk);
        chk("ready_before_accept", ready, 1'b1);
        data        = d;
        baud_div    = div;
        parity_mode = pm;
        stop2       = s2;
        valid       = 1'b1;
        push_frame(d, eff_p(div), pm, s2);
        @(posedge clk);
        #1;
        valid       = 1'b0;
        data        = ~d;
        baud_div    = div + 16'd3;
        parity_mode = ~pm;
        stop2       = ~s2;
    endtask

    task automatic drain_bits(input string tag);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            chk({tag, "_tx"}, tx, exp_q.pop_front());
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_nodone"}, done, 1'b0);
        end
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_ready"}, ready, 1'b1);
        chk({tag, "_busy0"}, busy, 1'b0);
        chk({tag, "_tx_idle"}, tx, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        data        = '0;
        valid       = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk         = 1'b0;
`endif
        #2;
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tx", tx, 1'b1);
        chk("idle_done", done, 1'b0);

        // 8N1, P=4, 0xA5: 40 bit clocks then done in the 41st cycle
        drive_accept(8'hA5, 16'd4, 2'b00, 1'b0);
        chk("t1_len", (exp_q.size() == 40), 1'b1);
        drain_bits("t1");
        check_done("t1");

        // Even parity on 0x07 gives 1, odd gives 0; 44-clock frames
        drive_accept(8'h07, 16'd4, 2'b01, 1'b0);
        chk("t2e_len", (exp_q.size() == 44), 1'b1);
        drain_bits("t2e");
        check_done("t2e");
        drive_accept(8'h07, 16'd4, 2'b10, 1'b0);
        drain_bits("t2o");
        check_done("t2o");
        // Reserved parity code sends no parity bit
        drive_accept(8'h5A, 16'd4, 2'b11, 1'b0);
        chk("t2r_len", (exp_q.size() == 40), 1'b1);
        drain_bits("t2r");
        check_done("t2r");

        // Back-to-back with two stop bits and valid held high
        @(negedge clk);
        data        = 8'h00;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        stop2       = 1'b1;
        valid       = 1'b1;
        push_frame(8'h00, 4, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        data = 8'hFF;
        drain_bits("t3a");
        check_done("t3a");
        push_frame(8'hFF, 4, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        drain_bits("t3b");
        check_done("t3b");
        @(negedge clk);
        chk("t3_idle_ready", ready, 1'b1);
        chk("t3_idle_tx", tx, 1'b1);

        // Divisor 0 and 1 both mean a 1-clock bit
        drive_accept(8'h3C, 16'd0, 2'b00, 1'b0);
        chk("t4a_len", (exp_q.size() == 10), 1'b1);
        drain_bits("t4a");
        check_done("t4a");
        drive_accept(8'hC3, 16'd1, 2'b00, 1'b0);
        drain_bits("t4b");
        check_done("t4b");

        // Reset during the third data bit
        drive_accept(8'h96, 16'd4, 2'b00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("t5_pre_tx", tx, exp_q.pop_front());
        end
        exp_q.delete();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_tx", tx, 1'b1);
        chk("t5_async_ready", ready, 1'b1);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_post_done", done, 1'b0);
            chk("t5_post_tx", tx, 1'b1);
        end
        drive_accept(8'h3C, 16'd4, 2'b10, 1'b0);
        drain_bits("t5n");
        check_done("t5n");

`ifdef UART_TX_BREAK_EN
        // Break for 20 cycles beats a simultaneous valid, then a 4-clock mark
        @(negedge clk);
        baud_div = 16'd4;
        data     = 8'h55;
        brk      = 1'b1;
        valid    = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk("t6_tx", tx, exp_q.pop_front());
            chk("t6_ready", ready, 1'b0);
            chk("t6_busy", busy, 1'b1);
            chk("t6_done", done, 1'b0);
            if (i == 19) brk = 1'b0;
        end
        @(negedge clk);
        chk("t6_end_ready", ready, 1'b1);
        chk("t6_end_done", done, 1'b0);
        chk("t6_end_tx", tx, 1'b1);
        drive_accept(8'h81, 16'd4, 2'b01, 1'b0);
        drain_bits("t6n");
        check_done("t6n");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
